// File: rtl/bus_glue_mux.sv
// Upstream-to-downstream bus glue: decodes a flat address space onto NCH
// register channels, registers strobes, and tracks reads with a tag pipeline.
module bus_glue_mux #(
  parameter int AW = 24,
  parameter int DW = 32,
  parameter int NCH = 2,
  parameter int SUB_AW = 12,
  parameter int RD_LAT = 1,
  parameter logic [DW-1:0] MISS_VAL = 32'hDEADBEEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AW-1:0]         u_addr,
  input  logic [DW-1:0]         u_wdata,
  input  logic                  u_wstb,
  input  logic                  u_rstb,
  output logic [DW-1:0]         u_rdata,
  output logic                  u_rvalid,
  output logic [NCH*SUB_AW-1:0] d_addr,
  output logic [NCH*DW-1:0]     d_wdata,
  output logic [NCH-1:0]        d_wstb,
  output logic [NCH-1:0]        d_rstb,
  input  logic [NCH*DW-1:0]     d_rdata,
  output logic [7:0]            miss_cnt
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW:0] NCH_V = (CW+1)'(NCH);

  logic [CW-1:0] sel;
  logic          hit;
  logic          any_stb;
  logic [RD_LAT:0] tag_valid;
  logic [RD_LAT:0] tag_miss;
  logic [CW-1:0]   tag_sel [RD_LAT+1];
  logic [DW-1:0]   ret_data;

  // A hit needs an in-range channel number and all address bits above it clear.
  assign sel     = u_addr[SUB_AW +: CW];
  assign hit     = ((u_addr >> (SUB_AW + CW)) == '0) && ({1'b0, sel} < NCH_V);
  assign any_stb = u_wstb | u_rstb;

  always_comb begin
    ret_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (tag_sel[RD_LAT] == CW'(k)) ret_data = d_rdata[k*DW +: DW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_wstb    <= '0;
      d_rstb    <= '0;
      d_addr    <= '0;
      d_wdata   <= '0;
      miss_cnt  <= '0;
      tag_valid <= '0;
      tag_miss  <= '0;
      for (int i = 0; i <= RD_LAT; i++) tag_sel[i] <= '0;
      u_rvalid  <= 1'b0;
      u_rdata   <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        d_wstb[k] <= u_wstb && hit && (sel == CW'(k));
        d_rstb[k] <= u_rstb && hit && (sel == CW'(k));
        if (any_stb) begin
          d_addr[k*SUB_AW +: SUB_AW] <= u_addr[SUB_AW-1:0];
          d_wdata[k*DW +: DW]        <= u_wdata;
        end
      end
      // A read and a write in the same cycle that both miss count once.
      if (any_stb && !hit && (miss_cnt != 8'hFF)) miss_cnt <= miss_cnt + 8'd1;
      tag_valid <= {tag_valid[RD_LAT-1:0], u_rstb};
      tag_miss  <= {tag_miss[RD_LAT-1:0], !hit};
      tag_sel[0] <= sel;
      for (int i = 1; i <= RD_LAT; i++) tag_sel[i] <= tag_sel[i-1];
      u_rvalid <= tag_valid[RD_LAT];
      if (tag_valid[RD_LAT]) u_rdata <= tag_miss[RD_LAT] ? MISS_VAL : ret_data;
    end
  end

endmodule

// File: tb/tb_bus_glue_mux.sv
// Randomized bench for bus_glue_mux against a flat-address reference model,
// plus directed runs of a 3-channel, 4-cycle-latency instance.
module tb_bus_glue_mux;

  localparam int AW = 24;
  localparam int DW = 32;
  localparam int NCH = 2;
  localparam int SUB_AW = 12;
  localparam int RD_LAT = 1;
  localparam logic [31:0] MISS = 32'hDEADBEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst = 1'b1;
  logic [AW-1:0]         u_addr = '0;
  logic [DW-1:0]         u_wdata = '0;
  logic                  u_wstb = 1'b0;
  logic                  u_rstb = 1'b0;
  logic [DW-1:0]         u_rdata;
  logic                  u_rvalid;
  logic [NCH*SUB_AW-1:0] d_addr;
  logic [NCH*DW-1:0]     d_wdata;
  logic [NCH-1:0]        d_wstb;
  logic [NCH-1:0]        d_rstb;
  logic [NCH*DW-1:0]     d_rdata;
  logic [7:0]            miss_cnt;

  bus_glue_mux #(.AW(AW), .DW(DW), .NCH(NCH), .SUB_AW(SUB_AW), .RD_LAT(RD_LAT),
                 .MISS_VAL(MISS)) dut (
    .clk(clk), .rst(rst), .u_addr(u_addr), .u_wdata(u_wdata), .u_wstb(u_wstb),
    .u_rstb(u_rstb), .u_rdata(u_rdata), .u_rvalid(u_rvalid), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_wstb(d_wstb), .d_rstb(d_rstb), .d_rdata(d_rdata),
    .miss_cnt(miss_cnt)
  );

  logic           rst3 = 1'b1;
  logic [23:0]    u_addr3 = '0;
  logic [31:0]    u_wdata3 = '0;
  logic           u_wstb3 = 1'b0;
  logic           u_rstb3 = 1'b0;
  logic [31:0]    u_rdata3;
  logic           u_rvalid3;
  logic [35:0]    d_addr3;
  logic [95:0]    d_wdata3;
  logic [2:0]     d_wstb3;
  logic [2:0]     d_rstb3;
  logic [95:0]    d_rdata3 = {32'h33333333, 32'h22222222, 32'h11111111};
  logic [7:0]     miss_cnt3;

  bus_glue_mux #(.AW(24), .DW(32), .NCH(3), .SUB_AW(12), .RD_LAT(4),
                 .MISS_VAL(MISS)) dut3 (
    .clk(clk), .rst(rst3), .u_addr(u_addr3), .u_wdata(u_wdata3), .u_wstb(u_wstb3),
    .u_rstb(u_rstb3), .u_rdata(u_rdata3), .u_rvalid(u_rvalid3), .d_addr(d_addr3),
    .d_wdata(d_wdata3), .d_wstb(d_wstb3), .d_rstb(d_rstb3), .d_rdata(d_rdata3),
    .miss_cnt(miss_cnt3)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Memory contents are stored XOR a per-location seed so zero-initialised
  // 2-state arrays read back as distinct, non-trivial values.
  function automatic logic [31:0] init_val(input int k, input int a);
    return 32'h5A000000 ^ (32'(k) << 20) ^ (32'(a) * 32'h00010003);
  endfunction

  bit   [31:0] resp_mem [NCH][4096];
  logic [31:0] resp_pipe [NCH][RD_LAT];

  always @(posedge clk) begin
    for (int k = 0; k < NCH; k++) begin
      resp_pipe[k][0] <= d_rstb[k] ?
        resp_mem[k][int'(d_addr[k*SUB_AW +: SUB_AW])] ^ init_val(k, int'(d_addr[k*SUB_AW +: SUB_AW])) :
        (32'hBAD00000 | 32'(k));
      for (int s = 1; s < RD_LAT; s++) resp_pipe[k][s] <= resp_pipe[k][s-1];
      if (d_wstb[k])
        resp_mem[k][int'(d_addr[k*SUB_AW +: SUB_AW])] <=
          d_wdata[k*DW +: DW] ^ init_val(k, int'(d_addr[k*SUB_AW +: SUB_AW]));
    end
  end

  always_comb begin
    d_rdata = '0;
    for (int k = 0; k < NCH; k++) d_rdata[k*DW +: DW] = resp_pipe[k][RD_LAT-1];
  end

  typedef struct {
    int          due;
    logic [31:0] data;
  } rd_t;

  rd_t         exp_q[$];
  bit   [31:0] ref_mem [NCH][4096];
  int          run_miss = 0;
  logic        pend_rst = 1'b1;
  logic [1:0]  pend_wstb = '0;
  logic [1:0]  pend_rstb = '0;
  logic        pend_chk = 1'b1;
  logic [11:0] pend_addr = '0;
  logic [31:0] pend_wdata = '0;

  logic        e_rst = 1'b0;
  logic [1:0]  e_wstb = '0;
  logic [1:0]  e_rstb = '0;
  logic        e_chk = 1'b0;
  logic [11:0] e_addr = '0;
  logic [31:0] e_wdata = '0;
  logic [7:0]  e_miss = '0;
  logic [31:0] hold_rdata = '0;

  // Expectations become visible on the edge that samples the matching inputs.
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    e_rst   <= pend_rst;
    e_wstb  <= pend_wstb;
    e_rstb  <= pend_rstb;
    e_chk   <= pend_chk;
    e_addr  <= pend_addr;
    e_wdata <= pend_wdata;
    e_miss  <= 8'(run_miss);
  end

  always @(negedge clk) begin
    logic exp_v;
    if (cyc >= 1) begin
      if (e_rst) hold_rdata = '0;
      exp_v = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        exp_v = 1'b1;
        hold_rdata = exp_q[0].data;
        exp_q.delete(0);
      end
      checkOutput("u_rvalid", 64'(u_rvalid), 64'(exp_v));
      checkOutput("u_rdata", 64'(u_rdata), 64'(hold_rdata));
      checkOutput("d_wstb", 64'(d_wstb), 64'(e_wstb));
      checkOutput("d_rstb", 64'(d_rstb), 64'(e_rstb));
      checkOutput("miss_cnt", 64'(miss_cnt), 64'(e_miss));
      if (e_chk) begin
        for (int k = 0; k < NCH; k++) begin
          checkOutput("d_addr", 64'(d_addr[k*SUB_AW +: SUB_AW]), 64'(e_addr));
          checkOutput("d_wdata", 64'(d_wdata[k*DW +: DW]), 64'(e_wdata));
        end
      end
    end
  end

  // One upstream cycle; the model works on flat addresses: channel = addr / 4096.
  task automatic applyStimulus(input logic r, input logic [23:0] a, input logic [31:0] wd,
                               input logic ws, input logic rs);
    int ch;
    int sub;
    bit hit;
    @(posedge clk);
    #1;
    rst = r; u_addr = a; u_wdata = wd; u_wstb = ws; u_rstb = rs;
    pend_wstb = '0;
    pend_rstb = '0;
    pend_chk  = 1'b0;
    if (r) begin
      pend_rst = 1'b1;
      run_miss = 0;
      pend_chk = 1'b1;
      pend_addr = '0;
      pend_wdata = '0;
      while (exp_q.size() > 0 && exp_q[exp_q.size()-1].due > cyc) exp_q.delete(exp_q.size()-1);
    end else begin
      pend_rst = 1'b0;
      ch  = int'(a) / 4096;
      sub = int'(a) % 4096;
      hit = (ch < NCH);
      if ((ws || rs) && hit) begin
        pend_chk   = 1'b1;
        pend_addr  = 12'(sub);
        pend_wdata = wd;
        pend_wstb  = 2'(ws) << ch;
        pend_rstb  = 2'(rs) << ch;
      end
      if (rs) exp_q.push_back('{cyc + RD_LAT + 2, hit ? (ref_mem[ch][sub] ^ init_val(ch, sub)) : MISS});
      if (ws && hit) ref_mem[ch][sub] = wd ^ init_val(ch, sub);
      if ((ws || rs) && !hit && run_miss < 255) run_miss++;
    end
  endtask

  initial begin
    logic [23:0] ra;
    int          kind;
    repeat (3) applyStimulus(1'b1, '0, '0, 1'b0, 1'b0);

    applyStimulus(1'b0, 24'h001004, 32'h00001234, 1'b1, 1'b0);
    applyStimulus(1'b0, 24'h000010, 32'hA5A5A5A5, 1'b1, 1'b0);
    applyStimulus(1'b0, 24'h000010, 32'h0, 1'b0, 1'b1);
    repeat (4) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);

    applyStimulus(1'b0, 24'h000020, 32'h10, 1'b1, 1'b0);
    applyStimulus(1'b0, 24'h001020, 32'h20, 1'b1, 1'b0);
    applyStimulus(1'b0, 24'h000024, 32'h11, 1'b1, 1'b0);
    applyStimulus(1'b0, 24'h001024, 32'h21, 1'b1, 1'b0);
    applyStimulus(1'b0, 24'h000020, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 24'h001020, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 24'h000024, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 24'h001024, 32'h0, 1'b0, 1'b1);
    repeat (4) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);

    applyStimulus(1'b0, 24'h100000, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 300; i++)
      applyStimulus(1'b0, 24'h100000 | 24'(i), 32'(i), (i % 2) == 0, ((i % 2) != 0) || ((i % 3) == 0));
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("miss_sat", 64'(miss_cnt), 64'hFF);

    for (int i = 0; i < 1500; i++) begin
      ra = 24'($urandom_range(0, NCH-1) * 4096 + $urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) ra[$urandom_range(13, 23)] = 1'b1;
      kind = $urandom_range(0, 3);
      applyStimulus($urandom_range(0, 63) == 0, ra, $urandom, kind[0], kind[1]);
    end
    repeat (6) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);

    // Three channels: channel number 3 is out of range and must miss.
    @(negedge clk);
    rst3 = 1'b0;
    @(negedge clk);
    u_addr3 = 24'h003000;
    u_rstb3 = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      u_rstb3 = 1'b0;
      checkOutput("n3_rvalid", 64'(u_rvalid3), 64'(i == 6));
      if (i == 6) checkOutput("n3_rdata", 64'(u_rdata3), 64'(MISS));
      checkOutput("n3_miss", 64'(miss_cnt3), 64'd1);
      checkOutput("n3_drstb", 64'(d_rstb3), 64'd0);
    end

    // Reset lands while a read is in flight; it must never complete.
    @(negedge clk);
    u_addr3 = 24'h001ABC;
    u_wdata3 = 32'hCAFE0000;
    u_rstb3 = 1'b1;
    @(negedge clk);
    u_rstb3 = 1'b0;
    rst3 = 1'b1;
    checkOutput("n3_hit_rstb", 64'(d_rstb3), 64'b010);
    @(negedge clk);
    rst3 = 1'b0;
    checkOutput("rst_drstb", 64'(d_rstb3), 64'd0);
    checkOutput("rst_dwstb", 64'(d_wstb3), 64'd0);
    checkOutput("rst_daddr", 64'(d_addr3), 64'd0);
    checkOutput("rst_dwdata", {32'h0, d_wdata3[95:64] | d_wdata3[63:32] | d_wdata3[31:0]}, 64'd0);
    checkOutput("rst_miss", 64'(miss_cnt3), 64'd0);
    checkOutput("rst_rdata", 64'(u_rdata3), 64'd0);
    for (int i = 0; i < 8; i++) begin
      checkOutput("rst_rvalid", 64'(u_rvalid3), 64'd0);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
